stream_gen: RTL and testbench

Parameterised stream source driving a valid/ready payload onto an interface port for a downstream interface consumer. On a `start` pulse it emits `count` beats of incrementing data beginning at `seed`, holds each beat under backpressure, then pulses `done`. It sits directly upstream of the interface-consuming module and is the stimulus stage for interface-parameter and generate-block regression tests.

---
 rtl/stream_gen_pkg.sv | 13 +
 rtl/stream_if.sv | 15 +
 rtl/stream_gen.sv | 105 ++++++++++
 tb/tb_stream_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_gen_pkg.sv
// Shared types and default sizes for the stream_gen source and its stream_if port.
package stream_gen_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_if.sv
// Valid/ready payload interface; the source drives valid/data, the sink drives ready.
interface stream_if
    import stream_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport src (output valid, output data, input ready);
    modport snk (input valid, input data, output ready);

endinterface

// File: rtl/stream_gen.sv
// Burst stream source: on start emits count incrementing beats from seed, then pulses done.
// Optional XOR checksum output enabled by defining STREAM_GEN_CHECKSUM_EN.
module stream_gen
    import stream_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] seed,
    stream_if.src            out_if,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
`ifdef STREAM_GEN_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] csum
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] sent_q,  sent_d;
    logic [WIDTH-1:0] data_q,  data_d;
`ifdef STREAM_GEN_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q,  csum_d;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        data_d  = data_q;
`ifdef STREAM_GEN_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sent_d = '0;
`ifdef STREAM_GEN_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (count != '0) begin
                        cnt_d   = count;
                        data_d  = seed;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (out_if.ready) begin
                    data_d = data_q + 1'b1;
                    sent_d = sent_q + 1'b1;
`ifdef STREAM_GEN_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                    if (sent_d == cnt_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sent_q  <= '0;
            data_q  <= '0;
`ifdef STREAM_GEN_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            data_q  <= data_d;
`ifdef STREAM_GEN_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Outputs decode straight from registered state, so reset clears them without waiting for a clock.
    assign out_if.valid = (state_q == RUN);
    assign out_if.data  = data_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign sent         = sent_q;
`ifdef STREAM_GEN_CHECKSUM_EN
    assign csum         = csum_q;
`endif

endmodule

// File: tb/tb_stream_gen.sv
// Self-checking bench for stream_gen: queue-based reference model plus directed literal checks.
module tb_stream_gen;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  seed  = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent;
`ifdef STREAM_GEN_CHECKSUM_EN
    logic [W-1:0]  csum;
`endif

    stream_if #(.WIDTH(W)) sif ();

    stream_gen #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .count  (count),
        .seed   (seed),
        .out_if (sif),
        .busy   (busy),
        .done   (done),
        .sent   (sent)
`ifdef STREAM_GEN_CHECKSUM_EN
        ,
        .csum   (csum)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a burst is a queue of payloads still to be delivered.
    logic [W-1:0]  m_q[$];
    logic          m_done = 1'b0;
    logic [CW-1:0] m_sent = '0;
    logic [W-1:0]  m_data = '0;
    logic [W-1:0]  m_csum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_done = 1'b0;
            m_sent = '0;
            m_data = '0;
            m_csum = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() != 0) begin
            if (sif.ready) begin
                m_csum = m_csum ^ m_q[0];
                m_data = W'(m_q[0] + 1);
                m_q.pop_front();
                m_sent = CW'(m_sent + 1);
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            m_sent = '0;
            m_csum = '0;
            if (count == '0) begin
                m_done = 1'b1;
            end else begin
                m_data = seed;
                for (int i = 0; i < int'(count); i++) m_q.push_back(W'(int'(seed) + i));
            end
        end
    end

    always @(negedge clk) begin
        check("valid", sif.valid, m_q.size() != 0);
        check("busy",  busy,      m_q.size() != 0);
        check("data",  sif.data,  (m_q.size() != 0) ? m_q[0] : m_data);
        check("done",  done,      m_done);
        check("sent",  sent,      m_sent);
`ifdef STREAM_GEN_CHECKSUM_EN
        check("csum",  csum,      m_csum);
`endif
    end

    // Observed transfers and pulses, compared against hand-written literals.
    logic [W-1:0] seen[$];
    logic [W-1:0] exp_q[$];
    int           done_cnt  = 0;
    int           valid_cnt = 0;

    always @(negedge clk) begin
        if (sif.valid && sif.ready) seen.push_back(sif.data);
        if (sif.valid) valid_cnt++;
        if (done) done_cnt++;
    end

    task automatic start_burst(input logic [CW-1:0] c, input logic [W-1:0] s);
        @(posedge clk); #1;
        start = 1'b1;
        count = c;
        seed  = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        #1;
        check({name, "_done_seen"}, done_cnt != d0, 1'b1);
    endtask

    task automatic check_seen(input string name);
        check({name, "_beats"}, seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
            check($sformatf("%s_beat%0d", name, i), seen[i], exp_q[i]);
        end
    endtask

    initial begin
        int d0;
        int v0;
        sif.ready = 1'b0;
        idle(2);
        check("rst_valid", sif.valid, 1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_done",  done,      1'b0);
        check("rst_sent",  sent,      8'd0);
        check("rst_data",  sif.data,  8'd0);
        rst_n = 1'b1;
        idle(1);

        // Basic burst
        sif.ready = 1'b1;
        seen.delete();
        d0 = done_cnt;
        start_burst(8'd4, 8'h10);
        check("basic_first_valid", sif.valid, 1'b1);
        check("basic_first_data",  sif.data,  8'h10);
        wait_done("basic", 20);
        idle(2);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        check_seen("basic");
        check("basic_pulses", done_cnt - d0, 1);
        check("basic_sent",   sent,          8'd4);
`ifdef STREAM_GEN_CHECKSUM_EN
        check("basic_csum",   csum,          8'h00);
`endif

        // Backpressure on beat 2
        seen.delete();
        d0 = done_cnt;
        start_burst(8'd3, 8'h10);
        @(posedge clk); #1;
        sif.ready = 1'b0;
        @(negedge clk);
        check("stall1_valid", sif.valid, 1'b1);
        check("stall1_data",  sif.data,  8'h11);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall2_valid", sif.valid, 1'b1);
        check("stall2_data",  sif.data,  8'h11);
        @(posedge clk); #1;
        sif.ready = 1'b1;
        wait_done("bp", 20);
        idle(2);
        exp_q = '{8'h10, 8'h11, 8'h12};
        check_seen("bp");
        check("bp_pulses", done_cnt - d0, 1);
        check("bp_sent",   sent,          8'd3);

        // Data wrap
        seen.delete();
        d0 = done_cnt;
        start_burst(8'd3, 8'hFE);
        wait_done("wrap", 20);
        idle(2);
        exp_q = '{8'hFE, 8'hFF, 8'h00};
        check_seen("wrap");
        check("wrap_pulses", done_cnt - d0, 1);
        check("wrap_idle_data", sif.data, 8'h01);

        // Zero-count burst
        d0 = done_cnt;
        v0 = valid_cnt;
        start_burst(8'd0, 8'h55);
        check("zero_done_now", done,      1'b1);
        check("zero_valid",    sif.valid, 1'b0);
        idle(3);
        check("zero_pulses",   done_cnt - d0,  1);
        check("zero_no_valid", valid_cnt - v0, 0);
        check("zero_sent",     sent,           8'd0);

        // start during RUN is ignored
        seen.delete();
        d0 = done_cnt;
        start_burst(8'd5, 8'h20);
        @(posedge clk); #1;
        start = 1'b1;
        count = 8'd2;
        seed  = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ign", 20);
        idle(3);
        exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        check_seen("ign");
        check("ign_pulses", done_cnt - d0, 1);
        check("ign_busy",   busy,          1'b0);
        check("ign_valid",  sif.valid,     1'b0);
        check("ign_sent",   sent,          8'd5);

        // Asynchronous reset mid-burst, then a fresh full burst
        start_burst(8'd6, 8'h40);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", sif.valid, 1'b0);
        check("arst_busy",  busy,      1'b0);
        check("arst_sent",  sent,      8'd0);
        check("arst_data",  sif.data,  8'd0);
        check("arst_done",  done,      1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen.delete();
        d0 = done_cnt;
        start_burst(8'd6, 8'h50);
        wait_done("fresh", 30);
        idle(2);
        exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        check_seen("fresh");
        check("fresh_pulses", done_cnt - d0, 1);
        check("fresh_sent",   sent,          8'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
